mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer for the CPU's single-port `mem` block. It shares the array between the instruction-fetch port (`i_*`) and the data-access port (`d_*`) of the pipelined RISC-V core, and runs each granted access through a fixed two-cycle sequence. Data accesses have priority, with a starvation guard that guarantees fetch progress. Misaligned word accesses are rejected before they reach memory.

## Interface
- `DATA_W`, 32: data and address width.
- `MAX_WAIT`, 4: consecutive denied fetch cycles after which fetch wins arbitration (range 1..15).
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch read request.
- `i_addr`  in  DATA_W  fetch byte address.
- `i_rdata`  out  DATA_W  fetch read data, valid while `i_done`.
- `i_done`  out  1  one-cycle completion pulse.
- `i_err`  out  1  misaligned fetch; pulses with `i_done`.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  DATA_W  data byte address.
- `d_wdata`  in  DATA_W  write data.
- `d_rdata`  out  DATA_W  read data, valid while `d_done`.
- `d_done`  out  1  one-cycle completion pulse.
- `d_err`  out  1  misaligned data access; pulses with `d_done`.
- `mem_addr`  out  DATA_W  to `mem` address.
- `mem_wdata`  out  DATA_W  to `mem` memIn.
- `mem_read`  out  1  to `mem` read.
- `mem_write`  out  1  to `mem` write; `mem` commits on the rising edge.
- `mem_rdata`  in  DATA_W  from `mem` memOut; combinational read.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - BUSY: drive memory for exactly one cycle.
  - ERR: report a misaligned access for one cycle.
- Arbitration happens only in IDLE, and only on requests that are high in that cycle.
  - Grant goes to `d` if `d_req` is high, unless `wait_cnt == MAX_WAIT` and `i_req` is high. In that case grant goes to `i`.
  - Otherwise grant goes to `i` if `i_req` is high.
  - Grant latches the owner, address, `d_we` and `d_wdata`.
- Alignment check:
  - Granted address has `[1:0] != 0`: IDLE→ERR.
  - Aligned: IDLE→BUSY.
- BUSY:
  - Outputs are registered.
  - `mem_addr` = latched address.
  - `mem_read` = ~we, `mem_write` = we, `mem_wdata` = latched wdata.
  - At the closing edge, `mem_rdata` is captured into the owner's rdata register (writes capture nothing), the owner's `done` register is set, and the FSM returns to IDLE.
- ERR: at the closing edge, the owner's `done` and `err` are set, its rdata is set to 0, and the FSM returns to IDLE.
- `done` and `err` are high for one cycle only; they clear at the next edge.
- Requesters hold req, addr and data stable until `done`.
  - Req still high during the `done` cycle counts as a new back-to-back request, arbitrated in that same IDLE cycle.
- `wait_cnt` (4 bits, saturates at `MAX_WAIT`):
  - +1 on each IDLE cycle where `i_req`=1 and `d` is granted.
  - Cleared when `i` is granted or `i_req`=0 in IDLE.
- All memory strobes are 0 outside BUSY. Never assert `mem_read` and `mem_write` together.

## Timing
- Request in IDLE cycle N → BUSY in cycle N+1 (strobes high, write commits at end of N+1) → `done` and rdata valid in cycle N+2.
- Misaligned request: ERR in N+1, `done`/`err` in N+2, memory untouched.
- Peak throughput: one access per 2 cycles. Back-to-back grants are possible because the `done` cycle is IDLE.
- Simultaneous `i_req`/`d_req`: `d` first, then `i` on the next IDLE. Fetch waits at most `MAX_WAIT` data grants.
- Reset values (asynchronous):
  - state = IDLE, `wait_cnt` = 0.
  - All outputs 0: `mem_*`, `*_rdata`, `*_done`, `*_err`.
- Reset asserted during BUSY drops `mem_write` immediately, before the closing edge, so no write commits. No `done` is issued for the aborted access.
- After reset deasserts, the first arbitration is on the next rising edge.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE=2'd0, BUSY=2'd1, ERR=2'd2)
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1)
  - ALIGN_MASK = 2'b11
  - default widths
- One sub-module, `arb_wait_counter`: saturating starvation counter. Inputs: inc, clr, MAX_WAIT. Output: `expired`.
- Everything else (FSM, latches, output registers) lives in `mem_arbiter`.

## Test plan
- Data write 0x12345678 to 16, 0x0 to 20, 0x89abcdef to 24, then read 16/20/24 → `d_done` 2 cycles after each request; reads return 0x12345678, 0x0, 0x89abcdef.
- `i_req` and `d_req` high in the same cycle (fetch addr 0, data read addr 16) → `d_done` first in N+2, `i_done` in N+4 with mem[0].
- `d_req` held continuously (back-to-back reads) with `i_req` high, `MAX_WAIT`=4 → fetch granted on the 5th arbitration, then data resumes.
- `d_addr` = 18 write → `d_done`+`d_err` in N+2, `mem_write` never high, mem[16] unchanged. `i_addr` = 3 → `i_err`.
- `reset` asserted mid-BUSY of a write of 0xdeadbeef to 28 → `mem_write` drops at once, mem[28] keeps its old value, all outputs 0, no `done`.
- Reset release followed by immediate requests → first BUSY cycle one edge after the request, `wait_cnt` starts at 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the two-port memory arbiter.
// Imported by mem_arbiter and arb_wait_counter.
package mem_arb_pkg;

    localparam int unsigned DataWDefault   = 32;
    localparam int unsigned MaxWaitDefault = 4;
    localparam int unsigned WaitCntW       = 4;

    localparam logic [1:0] AlignMask = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StErr  = 2'd2
    } state_e;

    typedef enum logic {
        OwnI = 1'b0,
        OwnD = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of fetch cycles lost to data grants.
// expired tells the arbiter that fetch must win the next tie.
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam logic [WaitCntW-1:0] MaxCnt = WaitCntW'(MAX_WAIT);

    logic [WaitCntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of the single-port mem block.
// Each grant runs IDLE -> BUSY|ERR -> IDLE; data wins unless fetch has starved.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = DataWDefault,
    parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;

    logic              idle, grant_d, grant_i, expired, wc_inc, wc_clr;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] mem_addr_d, mem_wdata_d, i_rdata_d, d_rdata_d;
    logic              mem_read_d, mem_write_d, i_done_d, i_err_d, d_done_d, d_err_d;

    assign idle     = (state_q == StIdle);
    assign grant_d  = idle && d_req && !(expired && i_req);
    assign grant_i  = idle && i_req && !grant_d;
    assign sel_addr = grant_d ? d_addr : i_addr;
    assign wc_inc   = idle && i_req && grant_d;
    assign wc_clr   = idle && (grant_i || !i_req);

    arb_wait_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .inc    (wc_inc),
        .clr    (wc_clr),
        .expired(expired)
    );

    // The memory-side output registers double as the latched address,
    // direction and write data for the BUSY cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        i_rdata_d   = i_rdata;
        d_rdata_d   = d_rdata;
        i_done_d    = 1'b0;
        i_err_d     = 1'b0;
        d_done_d    = 1'b0;
        d_err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_d || grant_i) begin
                    owner_d = grant_d ? OwnD : OwnI;
                    if ((sel_addr[1:0] & AlignMask) != 2'b00) begin
                        state_d = StErr;
                    end else begin
                        state_d     = StBusy;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = d_wdata;
                        mem_write_d = grant_d && d_we;
                        mem_read_d  = !(grant_d && d_we);
                    end
                end
            end
            StBusy: begin
                state_d = StIdle;
                if (owner_q == OwnD) begin
                    d_done_d = 1'b1;
                    if (!mem_write) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    i_done_d  = 1'b1;
                    i_rdata_d = mem_rdata;
                end
            end
            StErr: begin
                state_d = StIdle;
                if (owner_q == OwnD) begin
                    d_done_d  = 1'b1;
                    d_err_d   = 1'b1;
                    d_rdata_d = '0;
                end else begin
                    i_done_d  = 1'b1;
                    i_err_d   = 1'b1;
                    i_rdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Async reset clears mem_write mid-BUSY, so an aborted write never commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= OwnI;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_rdata   <= '0;
            i_done    <= 1'b0;
            i_err     <= 1'b0;
            d_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            i_rdata   <= i_rdata_d;
            i_done    <= i_done_d;
            i_err     <= i_err_d;
            d_rdata   <= d_rdata_d;
            d_done    <= d_done_d;
            d_err     <= d_err_d;
        end
    end

endmodule
